gpu_cmd_queue: RTL and testbench

- Upstream command front-end for the GPU draw/clear engine.
- The CPU writes draw parameters into staging registers over a simple register-write port. A write to the COMMAND register pushes a snapshot of those registers into a FIFO.
- The issue FSM pops entries only while the GPU is not busy. It drives the GPU's ctrl_* parameter inputs, and generates clean single-cycle rising edges on ctrl_draw/ctrl_clear.
- Issued parameters are held stable until the GPU drops busy.

---
 rtl/gpu_cmd_queue_pkg.sv | 24 ++
 rtl/gpu_cmd_queue_if.sv | 47 ++++
 rtl/gpu_cmd_queue_fifo.sv | 51 +++++
 rtl/gpu_cmd_queue.sv | 114 +++++++++++
 tb/tb_gpu_cmd_queue.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_cmd_queue_pkg.sv
// Shared constants and types for the GPU command queue.
package gpu_cmd_pkg;

  localparam logic [2:0] REG_ADDRESS     = 3'd0;
  localparam logic [2:0] REG_ADDR_XY     = 3'd1;
  localparam logic [2:0] REG_IMAGE_WIDTH = 3'd2;
  localparam logic [2:0] REG_SIZE        = 3'd3;
  localparam logic [2:0] REG_POS         = 3'd4;
  localparam logic [2:0] REG_CLEAR_COLOR = 3'd5;
  localparam logic [2:0] REG_COMMAND     = 3'd6;
  localparam logic [2:0] REG_STATUS_CLR  = 3'd7;

  localparam logic OP_DRAW  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  // Packed FIFO entry: op, address, addr_x, addr_y, image_width,
  // width, height, x, y, clear_color.
  function automatic int entry_width(input int fb_width, input int fb_height);
    return 1 + 32 + 3 * 16 + 2 * ($clog2(fb_width) + 2) + 2 * ($clog2(fb_height) + 2) + 16;
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_WAIT} issue_state_t;

endpackage

// File: rtl/gpu_cmd_queue_if.sv
// CPU register-write port, queue status and GPU control bundle.
interface gpu_cmd_queue_if #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240,
  parameter int DEPTH     = 8
);
  localparam int WW = $clog2(FB_WIDTH) + 2;
  localparam int HW = $clog2(FB_HEIGHT) + 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic          q_overflow;
  logic          q_idle;
  logic          gpu_busy;
  logic [31:0]   ctrl_address;
  logic [15:0]   ctrl_address_x;
  logic [15:0]   ctrl_address_y;
  logic [15:0]   ctrl_image_width;
  logic [WW-1:0] ctrl_width;
  logic [HW-1:0] ctrl_height;
  logic [WW-1:0] ctrl_x;
  logic [HW-1:0] ctrl_y;
  logic [15:0]   ctrl_clear_color;
  logic          ctrl_draw;
  logic          ctrl_clear;

  modport master (
    output wr_en, wr_addr, wr_data, gpu_busy,
    input  q_count, q_full, q_empty, q_overflow, q_idle,
    input  ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
    input  ctrl_width, ctrl_height, ctrl_x, ctrl_y, ctrl_clear_color,
    input  ctrl_draw, ctrl_clear
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, gpu_busy,
    output q_count, q_full, q_empty, q_overflow, q_idle,
    output ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
    output ctrl_width, ctrl_height, ctrl_x, ctrl_y, ctrl_clear_color,
    output ctrl_draw, ctrl_clear
  );
endinterface

// File: rtl/gpu_cmd_queue_fifo.sv
// Generic synchronous FIFO; head entry is presented combinationally.
module gpu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Acceptance uses registered full/empty, so a same-cycle pop never frees a slot early.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/gpu_cmd_queue.sv
// Command front-end: staging registers, command FIFO and issue FSM.
module gpu_cmd_queue
  import gpu_cmd_pkg::*;
#(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240,
  parameter int DEPTH     = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  gpu_cmd_queue_if.slave bus
);
  localparam int WW = $clog2(FB_WIDTH) + 2;
  localparam int HW = $clog2(FB_HEIGHT) + 2;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = entry_width(FB_WIDTH, FB_HEIGHT);

  logic [31:0]   st_addr;
  logic [15:0]   st_ax, st_ay, st_iw, st_cc;
  logic [WW-1:0] st_w, st_x;
  logic [HW-1:0] st_h, st_y;

  logic          push, pop, clr_ovf, overflow;
  logic [EW-1:0] fifo_din, fifo_dout;
  logic [CW-1:0] count;
  logic          full, empty;

  logic          e_op;
  logic [31:0]   e_addr;
  logic [15:0]   e_ax, e_ay, e_iw, e_cc;
  logic [WW-1:0] e_w, e_x;
  logic [HW-1:0] e_h, e_y;

  logic          op_r;
  issue_state_t  state, state_nxt;

  // Staging registers persist across pushes so only changed fields need rewriting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_addr <= '0; st_ax <= '0; st_ay <= '0; st_iw <= '0; st_cc <= '0;
      st_w <= '0; st_h <= '0; st_x <= '0; st_y <= '0;
    end else if (bus.wr_en) begin
      case (bus.wr_addr)
        REG_ADDRESS:     st_addr <= bus.wr_data;
        REG_ADDR_XY:     begin st_ax <= bus.wr_data[15:0]; st_ay <= bus.wr_data[31:16]; end
        REG_IMAGE_WIDTH: st_iw <= bus.wr_data[15:0];
        REG_SIZE:        begin st_w <= bus.wr_data[WW-1:0]; st_h <= bus.wr_data[16 +: HW]; end
        REG_POS:         begin st_x <= bus.wr_data[WW-1:0]; st_y <= bus.wr_data[16 +: HW]; end
        REG_CLEAR_COLOR: st_cc <= bus.wr_data[15:0];
        default:         ;
      endcase
    end
  end

  assign push     = bus.wr_en && (bus.wr_addr == REG_COMMAND);
  assign clr_ovf  = bus.wr_en && (bus.wr_addr == REG_STATUS_CLR) && bus.wr_data[0];
  assign fifo_din = {bus.wr_data[0], st_addr, st_ax, st_ay, st_iw, st_w, st_h, st_x, st_y, st_cc};
  assign {e_op, e_addr, e_ax, e_ay, e_iw, e_w, e_h, e_x, e_y, e_cc} = fifo_dout;

  gpu_cmd_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop),
    .din(fifo_din), .dout(fifo_dout), .count(count), .full(full), .empty(empty)
  );

  // Sticky drop flag; a dropped push and a clear cannot coincide (one write per cycle)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           overflow <= 1'b0;
    else if (push && full)  overflow <= 1'b1;
    else if (clr_ovf)       overflow <= 1'b0;
  end

  // Issue state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and pop decode
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE:   if (!empty && !bus.gpu_busy) begin pop = 1'b1; state_nxt = ST_STROBE; end
      ST_STROBE: state_nxt = ST_WAIT;
      ST_WAIT:   if (!bus.gpu_busy) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Parameters latch only on pop and stay put for the whole GPU operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r <= OP_DRAW;
      bus.ctrl_address <= '0; bus.ctrl_address_x <= '0; bus.ctrl_address_y <= '0;
      bus.ctrl_image_width <= '0; bus.ctrl_width <= '0; bus.ctrl_height <= '0;
      bus.ctrl_x <= '0; bus.ctrl_y <= '0; bus.ctrl_clear_color <= '0;
    end else if (pop) begin
      op_r <= e_op;
      bus.ctrl_address <= e_addr; bus.ctrl_address_x <= e_ax; bus.ctrl_address_y <= e_ay;
      bus.ctrl_image_width <= e_iw; bus.ctrl_width <= e_w; bus.ctrl_height <= e_h;
      bus.ctrl_x <= e_x; bus.ctrl_y <= e_y; bus.ctrl_clear_color <= e_cc;
    end
  end

  // Strobes decode straight from state so reset drops them without waiting for a clock
  assign bus.ctrl_draw  = (state == ST_STROBE) && (op_r == OP_DRAW);
  assign bus.ctrl_clear = (state == ST_STROBE) && (op_r == OP_CLEAR);

  assign bus.q_count    = count;
  assign bus.q_full     = full;
  assign bus.q_empty    = empty;
  assign bus.q_overflow = overflow;
  assign bus.q_idle     = empty && (state == ST_IDLE) && !bus.gpu_busy;
endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Scoreboard bench: stimulus queues expected commands, a monitor checks every strobe.
module tb_gpu_cmd_queue;
  localparam int FBW = 400, FBH = 240, DEPTH = 8;
  localparam int WW = $clog2(FBW) + 2;
  localparam int HW = $clog2(FBH) + 2;
  localparam logic [15:0] WMASK = 16'((1 << WW) - 1);
  localparam logic [15:0] HMASK = 16'((1 << HW) - 1);

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [15:0] ax, ay, iw, w, h, x, y, cc;
  } cmd_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0, errors = 0;

  cmd_t sb[$];
  cmd_t st;

  bit force_busy = 1'b0, gpu_quiet = 1'b0;
  int op_len = 0, gpu_cnt = 0;

  gpu_cmd_queue_if #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .DEPTH(DEPTH)) bus ();
  gpu_cmd_queue #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // GPU model: busy during the strobe (unless quiet) and for op_len cycles after it
  always_comb bus.gpu_busy = force_busy | (!gpu_quiet & (bus.ctrl_draw | bus.ctrl_clear)) | (gpu_cnt != 0);

  always @(posedge clk) begin
    if (bus.ctrl_draw | bus.ctrl_clear) gpu_cnt <= op_len;
    else if (gpu_cnt != 0)              gpu_cnt <= gpu_cnt - 1;
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] cur_params();
    return 192'({bus.ctrl_address, bus.ctrl_address_x, bus.ctrl_address_y, bus.ctrl_image_width,
                 bus.ctrl_width, bus.ctrl_height, bus.ctrl_x, bus.ctrl_y, bus.ctrl_clear_color});
  endfunction

  // Monitor: sampled on the falling edge
  logic [191:0] snap;
  bit  held = 0, prev_strobe = 0, prev_busy = 1, last_valid = 0;
  int  cyc = 0, last_cyc = 0;
  always @(negedge clk) begin
    cmd_t e;
    bit   strobe;
    cyc++;
    if (!reset_n) begin
      held = 0; prev_strobe = 0; last_valid = 0;
    end else begin
      strobe = bus.ctrl_draw | bus.ctrl_clear;
      if (held && prev_busy) chk("hold_params", cur_params(), snap);
      if (!prev_busy) held = 0;
      if (strobe) begin
        chk("strobe_exclusive", 192'(bus.ctrl_draw & bus.ctrl_clear), 192'(0));
        chk("strobe_single", 192'(prev_strobe), 192'(0));
        chk("busy_low_at_pop", 192'(prev_busy), 192'(0));
        if (last_valid) chk("strobe_gap", 192'(cyc - last_cyc >= 3), 192'(1));
        chk("expected_cmd_pending", 192'(sb.size() != 0), 192'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("op_draw", 192'(bus.ctrl_draw), 192'(!e.op));
          chk("op_clear", 192'(bus.ctrl_clear), 192'(e.op));
          chk("address", 192'(bus.ctrl_address), 192'(e.addr));
          chk("addr_xy", 192'({bus.ctrl_address_x, bus.ctrl_address_y}), 192'({e.ax, e.ay}));
          chk("image_width", 192'(bus.ctrl_image_width), 192'(e.iw));
          chk("size", 192'({bus.ctrl_width, bus.ctrl_height}), 192'({e.w[WW-1:0], e.h[HW-1:0]}));
          chk("pos", 192'({bus.ctrl_x, bus.ctrl_y}), 192'({e.x[WW-1:0], e.y[HW-1:0]}));
          chk("clear_color", 192'(bus.ctrl_clear_color), 192'(e.cc));
        end
        snap = cur_params(); held = 1; last_cyc = cyc; last_valid = 1;
      end
      prev_strobe = strobe;
    end
    prev_busy = bus.gpu_busy;
  end

  function automatic void model_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd0: st.addr = d;
      3'd1: begin st.ax = d[15:0]; st.ay = d[31:16]; end
      3'd2: st.iw = d[15:0];
      3'd3: begin st.w = d[15:0] & WMASK; st.h = d[31:16] & HMASK; end
      3'd4: begin st.x = d[15:0] & WMASK; st.y = d[31:16] & HMASK; end
      3'd5: st.cc = d[15:0];
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    st = '{default: 0};
    sb.delete();
  endfunction

  // All tasks start and end 1 time unit after a rising edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    model_write(a, d);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic cmd(input logic op, input bit accept);
    cmd_t e;
    logic [31:0] d;
    e = st; e.op = op;
    if (accept) sb.push_back(e);
    d = $urandom; d[0] = op;
    wr(3'd6, d);
  endtask

  task automatic drain();
    force_busy = 0; gpu_quiet = 0;
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
    chk("drain_done", 192'(sb.size()), 192'(0));
    repeat (60) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    // reset state
    chk("rst_q_empty", 192'(bus.q_empty), 192'(1));
    chk("rst_q_full", 192'(bus.q_full), 192'(0));
    chk("rst_q_count", 192'(bus.q_count), 192'(0));
    chk("rst_q_overflow", 192'(bus.q_overflow), 192'(0));
    chk("rst_q_idle", 192'(bus.q_idle), 192'(1));
    chk("rst_params", cur_params(), 192'(0));
    force_busy = 1; #1;
    chk("rst_q_idle_busy", 192'(bus.q_idle), 192'(0));
    force_busy = 0;
    @(posedge clk); #1 reset_n = 1'b1;

    // basic draw and its latency
    wr(3'd0, 32'h1000); wr(3'd1, 32'h00020001); wr(3'd2, 32'd64);
    wr(3'd3, 32'h00100010); wr(3'd4, 32'h00200010);
    cmd(1'b0, 1);
    chk("t1_count", 192'(bus.q_count), 192'(1));
    chk("t1_no_draw_yet", 192'(bus.ctrl_draw), 192'(0));
    @(posedge clk); #1;
    chk("t1_draw", 192'(bus.ctrl_draw), 192'(1));
    chk("t1_address", 192'(bus.ctrl_address), 192'(32'h1000));
    chk("t1_x", 192'(bus.ctrl_x), 192'(16));
    chk("t1_y", 192'(bus.ctrl_y), 192'(32));
    chk("t1_width", 192'(bus.ctrl_width), 192'(16));
    chk("t1_q_empty", 192'(bus.q_empty), 192'(1));
    @(posedge clk); #1;
    chk("t1_draw_fall", 192'(bus.ctrl_draw), 192'(0));
    drain();

    // three commands queued behind busy
    op_len = 2; force_busy = 1;
    wr(3'd4, 32'h00050007); cmd(1'b0, 1);
    wr(3'd4, 32'h00060008); cmd(1'b1, 1);
    cmd(1'b0, 1);
    repeat (5) @(posedge clk); #1;
    chk("t2_count", 192'(bus.q_count), 192'(3));
    drain();

    // long operation holds parameters and blocks the next pop
    op_len = 50;
    cmd(1'b0, 1);
    wr(3'd4, 32'h00110022); cmd(1'b0, 1);
    repeat (30) @(posedge clk); #1;
    chk("t3_pending", 192'(bus.q_count), 192'(1));
    drain();
    op_len = 1;

    // overflow and push-while-popping-when-full
    force_busy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      wr(3'd4, $urandom); cmd(1'($urandom_range(0, 1)), 1);
    end
    chk("t4_full", 192'(bus.q_full), 192'(1));
    chk("t4_no_ovf", 192'(bus.q_overflow), 192'(0));
    cmd(1'b0, 0);
    chk("t4_ovf", 192'(bus.q_overflow), 192'(1));
    chk("t4_count", 192'(bus.q_count), 192'(DEPTH));
    wr(3'd7, 32'h1);
    chk("t4_ovf_clr", 192'(bus.q_overflow), 192'(0));
    bus.wr_en = 1; bus.wr_addr = 3'd6; bus.wr_data = '0; force_busy = 0;
    @(posedge clk); #1 bus.wr_en = 0;
    chk("t4_pop_push_full_count", 192'(bus.q_count), 192'(DEPTH - 1));
    chk("t4_pop_push_full_ovf", 192'(bus.q_overflow), 192'(1));
    wr(3'd7, 32'h2);
    chk("t4_ovf_clr_bit0_only", 192'(bus.q_overflow), 192'(1));
    wr(3'd7, 32'h1);
    chk("t4_ovf_clr2", 192'(bus.q_overflow), 192'(0));
    drain();

    // clear command
    wr(3'd5, 32'h0000F801);
    cmd(1'b1, 1);
    @(posedge clk); #1;
    chk("t5_clear", 192'(bus.ctrl_clear), 192'(1));
    chk("t5_no_draw", 192'(bus.ctrl_draw), 192'(0));
    chk("t5_color", 192'(bus.ctrl_clear_color), 192'(16'hF801));
    drain();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      int r;
      r = $urandom_range(0, 9);
      op_len = $urandom_range(0, 4);
      gpu_quiet = ($urandom_range(0, 7) == 0);
      force_busy = ($urandom_range(0, 5) == 0);
      if (r <= 4)      wr(3'($urandom_range(0, 5)), $urandom);
      else if (r <= 7) begin
        if (sb.size() < DEPTH) cmd(1'($urandom_range(0, 1)), 1);
        else begin @(posedge clk); #1; end
      end
      else if (r == 8) begin
        wr(3'd3, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      end
      else begin @(posedge clk); #1; end
    end
    drain();
    chk("rnd_no_ovf", 192'(bus.q_overflow), 192'(0));
    chk("rnd_idle", 192'(bus.q_idle), 192'(1));

    // reset during WAIT with entries still queued
    op_len = 50;
    wr(3'd0, 32'hDEAD0000); wr(3'd5, 32'h1234);
    cmd(1'b0, 1); cmd(1'b1, 1); cmd(1'b0, 1);
    for (int i = 0; i < 50 && sb.size() != 2; i++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    chk("t6_queued", 192'(bus.q_count), 192'(2));
    #2 reset_n = 1'b0; model_reset();
    #1;
    chk("t6_params_zero", cur_params(), 192'(0));
    chk("t6_strobes_zero", 192'({bus.ctrl_draw, bus.ctrl_clear}), 192'(0));
    chk("t6_count_zero", 192'(bus.q_count), 192'(0));
    chk("t6_empty", 192'(bus.q_empty), 192'(1));
    chk("t6_idle_tracks_busy", 192'(bus.q_idle), 192'(!bus.gpu_busy));
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    repeat (70) @(posedge clk); #1;
    chk("t6_still_empty", 192'(bus.q_count), 192'(0));

    // reset while the strobe is high
    op_len = 0;
    cmd(1'b0, 1);
    @(posedge clk); #1;
    chk("t7_draw_high", 192'(bus.ctrl_draw), 192'(1));
    reset_n = 1'b0; model_reset();
    #1;
    chk("t7_draw_forced_low", 192'(bus.ctrl_draw), 192'(0));
    @(posedge clk); #1 reset_n = 1'b1;
    // staging registers must come back as zero
    cmd(1'b0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
